// File: rtl/sdes_decrypt_core.sv
// Iterative S-DES decryption core: 8-bit ciphertext + 10-bit key in, 8-bit plaintext out.
// Latency: out_valid rises on the 4th rising edge counting the accepting edge; one block per 5 cycles max.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - ciphertext/key valid;  in_ready - core idle and able to accept
//   in_data   - ciphertext (bit7 = S-DES bit 1)
//   in_key    - key (bit9 = S-DES bit 1)
//   mode      - only with SDES_DEC_ENC_MODE_EN: 1 = encrypt (K1 then K2), 0 = decrypt
//   out_valid - plaintext valid;  out_ready - downstream accepts
//   out_data  - plaintext (cleared on pop when CLEAR_ON_POP = 1)
//   busy      - high in every state except IDLE
// Build option: define SDES_DEC_ENC_MODE_EN to add the mode port.
module sdes_decrypt_core #(
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
`ifdef SDES_DEC_ENC_MODE_EN
  input  logic       mode,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    ROUND1 = 3'd2,
    ROUND2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Permutations below use 1-based S-DES numbering: bit i of an N-bit vector is x[N-i].

  // P10 = 3 5 2 7 4 10 1 9 8 6
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // P8 = 6 3 7 4 8 5 10 9
  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  // Rotate each 5-bit half left by one.
  function automatic logic [9:0] ls1(input logic [9:0] k);
    return {k[8:5], k[9], k[3:0], k[4]};
  endfunction

  // IP = 2 6 3 1 4 8 5 7
  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  // IP^-1 = 4 1 3 5 7 2 8 6
  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  // EP = 4 1 2 3 2 3 4 1
  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  // P4 = 2 4 3 1
  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // Index is {row, col}.
  function automatic logic [1:0] s0(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:  v = 2'd1;  4'd1:  v = 2'd0;  4'd2:  v = 2'd3;  4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;  4'd5:  v = 2'd2;  4'd6:  v = 2'd1;  4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;  4'd9:  v = 2'd2;  4'd10: v = 2'd1;  4'd11: v = 2'd3;
      4'd12: v = 2'd3;  4'd13: v = 2'd1;  4'd14: v = 2'd3;  default: v = 2'd2;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:  v = 2'd0;  4'd1:  v = 2'd1;  4'd2:  v = 2'd2;  4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;  4'd5:  v = 2'd0;  4'd6:  v = 2'd1;  4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;  4'd9:  v = 2'd0;  4'd10: v = 2'd1;  4'd11: v = 2'd0;
      4'd12: v = 2'd2;  4'd13: v = 2'd1;  4'd14: v = 2'd0;  default: v = 2'd3;
    endcase
    return v;
  endfunction

  // Round function F(R, K) = P4(sbox(EP(R) ^ K)).
  // S0 row = {b1,b4}, col = {b2,b3}; S1 row = {b5,b8}, col = {b6,b7}.
  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] e;
    e = ep(r) ^ k;
    return p4({s0({e[7], e[4], e[6], e[5]}), s1({e[3], e[0], e[2], e[1]})});
  endfunction

  state_t     state_q, state_d;
  logic [7:0] blk_q;
  logic [9:0] key_q;
  logic [7:0] k1_q, k2_q;
  logic [7:0] lr_q;     // {L, R} halves of the block between rounds
  logic [7:0] out_data_q;

  // Key schedule: K1 after LS-1, K2 after two further left shifts.
  logic [9:0] p10_w, sh1_w, sh3_w;
  logic [7:0] k1_w, k2_w;
  assign p10_w = p10(key_q);
  assign sh1_w = ls1(p10_w);
  assign sh3_w = ls1(ls1(sh1_w));
  assign k1_w  = p8(sh1_w);
  assign k2_w  = p8(sh3_w);

  // Subkey order: decrypt uses K2 then K1; encrypt mode reverses it.
  logic [7:0] key_r1, key_r2;
`ifdef SDES_DEC_ENC_MODE_EN
  logic mode_q;
  assign key_r1 = mode_q ? k1_q : k2_q;
  assign key_r2 = mode_q ? k2_q : k1_q;
`else
  assign key_r1 = k2_q;
  assign key_r2 = k1_q;
`endif

  logic [7:0] round_key;
  logic [3:0] new_l;
  assign round_key = (state_q == ROUND1) ? key_r1 : key_r2;
  assign new_l     = lr_q[7:4] ^ f_round(lr_q[3:0], round_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      key_q      <= '0;
      k1_q       <= '0;
      k2_q       <= '0;
      lr_q       <= '0;
      out_data_q <= '0;
`ifdef SDES_DEC_ENC_MODE_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q <= in_data;
            key_q <= in_key;
`ifdef SDES_DEC_ENC_MODE_EN
            mode_q <= mode;
`endif
          end
        end
        KEYGEN: begin
          k1_q <= k1_w;
          k2_q <= k2_w;
          lr_q <= ip(blk_q);
        end
        ROUND1: lr_q <= {lr_q[3:0], new_l};  // fk then swap halves
        ROUND2: out_data_q <= ip_inv({new_l, lr_q[3:0]});
        DONE: begin
          if (out_ready && CLEAR_ON_POP) out_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = KEYGEN;
      end
      KEYGEN: state_d = ROUND1;
      ROUND1: state_d = ROUND2;
      ROUND2: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = out_data_q;

endmodule
